// File: rtl/alu_arbiter_if.sv
// ============================================================================
// alu_arbiter_if : requester, response and ALU-drive bundle for alu_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [15:0] a0, a1, b0, b1;
  logic [3:0]  sh0, sh1;
  logic [15:0] ins0, ins1;
  logic        flush;
  logic        gnt0, gnt1;
  logic        rsp_valid0, rsp_valid1;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic [2:0]  flags;
  logic        busy;
  logic [15:0] alu_src0, alu_src1, alu_instr;
  logic [3:0]  alu_op, alu_shamt;
  logic [2:0]  alu_flags_in;
  logic [15:0] alu_dst;
  logic        alu_v, alu_z, alu_n;

  modport slave (
    input  req0, req1, op0, op1, a0, a1, b0, b1, sh0, sh1, ins0, ins1, flush,
    input  alu_dst, alu_v, alu_z, alu_n,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, rsp_flags, flags, busy,
    output alu_src0, alu_src1, alu_instr, alu_op, alu_shamt, alu_flags_in
  );

  modport master (
    output req0, req1, op0, op1, a0, a1, b0, b1, sh0, sh1, ins0, ins1, flush,
    output alu_dst, alu_v, alu_z, alu_n,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, rsp_flags, flags, busy,
    input  alu_src0, alu_src1, alu_instr, alu_op, alu_shamt, alu_flags_in
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : round-robin two-requester sequencer for the shared 16-bit ALU
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter bit FLAGS_OWNER = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] c_ALU_AND = 4'h2;
  localparam logic [3:0] c_ALU_NOP = 4'hF;

  logic        r_last;
  logic        r_issValid;
  logic        r_issId;
  logic [3:0]  r_issOp;
  logic [15:0] r_issA;
  logic [15:0] r_issB;
  logic [3:0]  r_issSh;
  logic [15:0] r_issIns;
  logic        r_rspValid0;
  logic        r_rspValid1;
  logic [15:0] r_rspData;
  logic [2:0]  r_rspFlags;
  logic [2:0]  r_flags;

  logic w_gnt0, w_gnt1, w_xfer, w_issNop, w_drive, w_capture;
  logic [2:0] w_aluFlags;

  // r_last == 1 means requester 1 was granted last, so requester 0 wins a tie.
  assign w_gnt0 = !rst && !bus.flush && bus.req0 && (!bus.req1 || r_last);
  assign w_gnt1 = !rst && !bus.flush && bus.req1 && (!bus.req0 || !r_last);
  assign w_xfer = w_gnt0 || w_gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_issValid <= 1'b0;
      r_issId    <= 1'b0;
      r_issOp    <= 4'h0;
      r_issA     <= 16'h0;
      r_issB     <= 16'h0;
      r_issSh    <= 4'h0;
      r_issIns   <= 16'h0;
    end else begin
      r_issValid <= w_xfer;
      if (w_xfer) begin
        r_last   <= w_gnt1;
        r_issId  <= w_gnt1;
        r_issOp  <= w_gnt1 ? bus.op1  : bus.op0;
        r_issA   <= w_gnt1 ? bus.a1   : bus.a0;
        r_issB   <= w_gnt1 ? bus.b1   : bus.b0;
        r_issSh  <= w_gnt1 ? bus.sh1  : bus.sh0;
        r_issIns <= w_gnt1 ? bus.ins1 : bus.ins0;
      end
    end
  end

  // NOP is never shown to the ALU; its dst feedback path would corrupt the result.
  assign w_issNop = (r_issOp == c_ALU_NOP);
  assign w_drive  = r_issValid && !w_issNop;

  assign bus.alu_op       = w_drive ? r_issOp  : c_ALU_AND;
  assign bus.alu_src0     = w_drive ? r_issA   : 16'h0;
  assign bus.alu_src1     = w_drive ? r_issB   : 16'h0;
  assign bus.alu_shamt    = w_drive ? r_issSh  : 4'h0;
  assign bus.alu_instr    = w_drive ? r_issIns : 16'h0;
  assign bus.alu_flags_in = r_flags;

  assign w_aluFlags = {bus.alu_v, bus.alu_z, bus.alu_n};
  assign w_capture  = r_issValid && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspValid0 <= 1'b0;
      r_rspValid1 <= 1'b0;
      r_rspData   <= 16'h0;
      r_rspFlags  <= 3'b000;
      r_flags     <= 3'b000;
    end else begin
      r_rspValid0 <= w_capture && !r_issId;
      r_rspValid1 <= w_capture && r_issId;
      if (w_capture) begin
        r_rspData  <= w_issNop ? 16'h0   : bus.alu_dst;
        r_rspFlags <= w_issNop ? r_flags : w_aluFlags;
        if ((r_issId == FLAGS_OWNER) && !w_issNop) begin
          r_flags <= w_aluFlags;
        end
      end
    end
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.rsp_valid0 = r_rspValid0;
  assign bus.rsp_valid1 = r_rspValid1;
  assign bus.rsp_data   = r_rspData;
  assign bus.rsp_flags  = r_rspFlags;
  assign bus.flags      = r_flags;
  assign bus.busy       = r_issValid;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : vector table plus scoreboard for alu_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND = 4'h2, NOP = 4'hF;

  typedef struct {
    bit          id;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [15:0] expData;
    logic [2:0]  expFlags, expArch;
  } vec_t;

  typedef struct {
    bit          id;
    logic [15:0] data;
    logic [2:0]  flags, arch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_arbiter_if bus();
  alu_arbiter #(.FLAGS_OWNER(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t pend [2];
  exp_t q [$];
  logic [2:0] modelArch = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Saturating ALU model: arith ops set flags, AND and others pass flags through.
  logic [15:0] aluR;
  logic        aluOv;
  always_comb begin
    aluR  = 16'h0;
    aluOv = 1'b0;
    bus.alu_dst = 16'h0;
    {bus.alu_v, bus.alu_z, bus.alu_n} = bus.alu_flags_in;
    case (bus.alu_op)
      ADD, SUB: begin
        if (bus.alu_op == ADD) begin
          aluR  = bus.alu_src0 + bus.alu_src1;
          aluOv = (bus.alu_src0[15] == bus.alu_src1[15]) && (aluR[15] != bus.alu_src0[15]);
        end else begin
          aluR  = bus.alu_src0 - bus.alu_src1;
          aluOv = (bus.alu_src0[15] != bus.alu_src1[15]) && (aluR[15] != bus.alu_src0[15]);
        end
        bus.alu_dst = aluOv ? (bus.alu_src0[15] ? 16'h8000 : 16'h7FFF) : aluR;
        bus.alu_v = aluOv;
        bus.alu_z = (bus.alu_dst == 16'h0);
        bus.alu_n = bus.alu_dst[15];
      end
      AND: bus.alu_dst = bus.alu_src0 & bus.alu_src1;
      default: bus.alu_dst = 16'h0;
    endcase
  end

  // Scoreboard monitor: push on transfer, pop one edge later.
  logic mT0, mT1, mFl;
  exp_t mExp, mPop;
  always @(posedge clk) begin
    mT0  = bus.req0 && bus.gnt0;
    mT1  = bus.req1 && bus.gnt1;
    mFl  = bus.flush;
    mExp = mT1 ? pend[1] : pend[0];
    #1;
    if (!rst) begin
      if (q.size() > 0) begin
        mPop = q.pop_front();
        if (mFl) begin
          check("flushed rsp_valid", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);
        end else begin
          check("rsp_valid id", {30'd0, bus.rsp_valid1, bus.rsp_valid0},
                mPop.id ? 32'd2 : 32'd1);
          check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, mPop.data});
          check("rsp_flags", {29'd0, bus.rsp_flags}, {29'd0, mPop.flags});
          modelArch = mPop.arch;
        end
      end else begin
        check("idle rsp_valid", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);
      end
      check("arch flags", {29'd0, bus.flags}, {29'd0, modelArch});
      if (mT0 || mT1) q.push_back(mExp);
    end
  end

  always @(posedge rst) begin
    q.delete();
    modelArch = 3'b000;
  end

  task automatic drive(input vec_t v);
    if (v.id) begin
      bus.req1 = 1'b1; bus.op1 = v.op; bus.a1 = v.a; bus.b1 = v.b;
    end else begin
      bus.req0 = 1'b1; bus.op0 = v.op; bus.a0 = v.a; bus.b0 = v.b;
    end
    pend[v.id] = '{v.id, v.expData, v.expFlags, v.expArch};
  endtask

  task automatic send(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check("single grant", {31'd0, v.id ? bus.gnt1 : bus.gnt0}, 32'd1);
    @(posedge clk);
    #1;
    if (v.id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.flush = 0;
    bus.op0 = 0; bus.op1 = 0; bus.a0 = 0; bus.a1 = 0; bus.b0 = 0; bus.b1 = 0;
    bus.sh0 = 4'h3; bus.sh1 = 4'h5; bus.ins0 = 16'h1000; bus.ins1 = 16'h2000;

    vecs[0] = '{1'b0, ADD, 16'h7000, 16'h2000, 16'h7FFF, 3'b100, 3'b100};
    vecs[1] = '{1'b1, SUB, 16'h0005, 16'h0005, 16'h0000, 3'b010, 3'b100};
    vecs[2] = '{1'b0, ADD, 16'h0001, 16'h0001, 16'h0002, 3'b000, 3'b000};
    vecs[3] = '{1'b0, ADD, 16'h8000, 16'h8000, 16'h8000, 3'b101, 3'b101};
    vecs[4] = '{1'b1, AND, 16'hFFFF, 16'h00F0, 16'h00F0, 3'b101, 3'b101};
    vecs[5] = '{1'b0, AND, 16'h1234, 16'h00FF, 16'h0034, 3'b101, 3'b101};
    vecs[6] = '{1'b0, SUB, 16'h0003, 16'h0005, 16'hFFFE, 3'b001, 3'b001};
    vecs[7] = '{1'b0, NOP, 16'h1111, 16'h2222, 16'h0000, 3'b001, 3'b001};
    vecs[8] = '{1'b1, ADD, 16'h0000, 16'h0000, 16'h0000, 3'b010, 3'b001};

    // Reset state, including grant suppression with a request pending.
    #12;
    bus.req0 = 1'b1;
    #1;
    check("reset gnt0", {31'd0, bus.gnt0}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset rsp_valid", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);
    check("reset flags", {29'd0, bus.flags}, 32'd0);
    check("reset rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    check("reset alu_op", {28'd0, bus.alu_op}, {28'd0, AND});
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) send(vecs[i]);

    // Reset between transfer and capture drops the op and clears state.
    @(negedge clk);
    drive('{1'b0, ADD, 16'h7000, 16'h2000, 16'h7FFF, 3'b100, 3'b100});
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, bus.busy}, 32'd0);
    check("midrst flags", {29'd0, bus.flags}, 32'd0);
    check("midrst rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    check("midrst rsp_flags", {29'd0, bus.rsp_flags}, 32'd0);
    #1;
    rst = 1'b0;

    // Both requesting: grants alternate starting with requester 0.
    @(negedge clk);
    drive('{1'b0, ADD, 16'h0001, 16'h0001, 16'h0002, 3'b000, 3'b000});
    drive('{1'b1, ADD, 16'h0002, 16'h0003, 16'h0005, 3'b000, 3'b000});
    for (int k = 0; k < 4; k++) begin
      #1;
      check("alt gnt0", {31'd0, bus.gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("alt gnt1", {31'd0, bus.gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Flush the cycle after a transfer: op dropped, grant withheld.
    send('{1'b0, ADD, 16'h7000, 16'h2000, 16'h7FFF, 3'b100, 3'b100});
    @(negedge clk);
    drive('{1'b0, ADD, 16'h0001, 16'h0001, 16'h0002, 3'b000, 3'b000});
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    drive('{1'b0, SUB, 16'h0003, 16'h0005, 16'hFFFE, 3'b001, 3'b001});
    #1;
    check("flush gnt0", {31'd0, bus.gnt0}, 32'd0);
    check("flush busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("post-flush gnt0", {31'd0, bus.gnt0}, 32'd1);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;

    // NOP is replaced by the idle drive while it sits in the issue stage.
    @(negedge clk);
    drive('{1'b0, NOP, 16'h1234, 16'h5678, 16'h0000, 3'b001, 3'b001});
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    check("nop busy", {31'd0, bus.busy}, 32'd1);
    check("nop alu_op", {28'd0, bus.alu_op}, {28'd0, AND});
    check("nop alu_src0", {16'd0, bus.alu_src0}, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer in front of the shared 16-bit saturating ALU. It accepts operations from the pipeline execute stage (requester 0) and the auxiliary address/DMA engine (requester 1) and grants them round-robin. Each accepted operation is registered into an issue stage that drives the combinational ALU, and the result is captured into a response register. The block owns the architectural {V,Z,N} flags register and commits flags only for the owner requester.

## Interface
- FLAGS_OWNER, 0: index of the requester whose results commit to the flags register.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request valid; hold high with payload stable until granted.
- op0 / op1  in  4  ALU operation code (defines.v ALU_* encodings).
- a0 / a1, b0 / b1  in  16  operands; a drives ALU src0, b drives ALU src1.
- sh0 / sh1  in  4  shift amount.
- ins0 / ins1  in  16  instruction word (bits 15:12 select flag-preserve opcodes inside the ALU).
- flush  in  1  synchronous kill of the issue stage.
- gnt0 / gnt1  out  1  combinational grant; a transfer occurs at a rising edge where req and gnt are both high.
- rsp_valid0 / rsp_valid1  out  1  one-cycle response strobe per requester.
- rsp_data  out  16  result.
- rsp_flags  out  3  {V,Z,N} produced by the op.
- flags  out  3  architectural {V,Z,N} register.
- busy  out  1  issue stage occupied.
- alu_src0, alu_src1, alu_instr  out  16; alu_op, alu_shamt  out  4; alu_flags_in  out  3: ALU drive.
- alu_dst  in  16; alu_v, alu_z, alu_n  in  1: ALU results.

## Operation
- Arbitration: a last-grant pointer `last` resets to 1, so requester 0 wins the first tie. With exactly one req high, that requester is granted. With both high, the requester != last is granted. `last` updates on every transfer. gnt0 and gnt1 are one-hot or zero. Both are 0 while rst is high or while flush is high.
- Issue stage, one entry: on a transfer it loads {id, op, a, b, sh, ins} and sets valid. Without a new transfer, valid clears at the next edge. Throughput is one operation per cycle; there is no backpressure.
- ALU drive: while the issue stage is valid, its fields drive the alu_* outputs, and alu_flags_in = flags.
  - When the issue stage is empty, drive alu_op = ALU_AND with zero operands and ins = 0.
  - An ALU_NOP op is never presented to the ALU, because the ALU's NOP path feeds dst back to itself. It is replaced by the idle drive above.
- Response stage: at the edge following issue, capture alu_dst into rsp_data and {alu_v, alu_z, alu_n} into rsp_flags, and pulse rsp_valid[id] for one cycle.
  - For ALU_NOP: rsp_data = 0 and rsp_flags = flags (current value).
  - rsp_data and rsp_flags hold their values when no response is pending.
- Flags commit: at the same edge as response capture, if id == FLAGS_OWNER and op != ALU_NOP, then flags <= {alu_v, alu_z, alu_n}. Otherwise flags hold.
  - The ALU itself preserves flags for LLB/LW/SW/B opcodes and for non-arith ops.
  - Back-to-back owner ops see the previous op's committed flags; no forwarding is needed.
- flush: the issue stage is invalidated at the edge. That op produces no response and no flag commit. No grant is given in the flush cycle. The response stage already holding a result still completes.
- busy = issue-stage valid.

## Timing
- Reset (async, immediate): gnt0 = gnt1 = 0, rsp_valid0/1 = 0, rsp_data = 0, rsp_flags = 0, flags = 0, busy = 0, last = 1, issue stage empty (idle ALU drive).
- Latency: transfer at edge E0, ALU evaluates during cycle E0..E1, capture at E1. rsp_valid is high from E1 to E2, and flags show the new value after E1.
- Simultaneous events:
  - A transfer and a response capture in the same edge are independent.
  - A flush and a transfer cannot coincide, because grants are suppressed during flush.
- Reset asserted mid-operation drops in-flight ops: no response strobe and no flag commit. Arbitration restarts with requester 0 priority.

## Test plan
- Single request, owner: req0 with op ADD, a = 0x7000, b = 0x2000 -> gnt0 at E0, rsp_valid0 after E1, rsp_data = 0x7FFF, rsp_flags = 3'b100, flags = 3'b100.
- Both requesting continuously for 4 cycles after reset -> grants alternate 0,1,0,1. Responses follow 1 cycle after each grant with matching rsp_valid id.
- Non-owner flags: req1 SUB 0x0005 - 0x0005 -> rsp_data = 0, rsp_flags = 3'b010, flags unchanged from prior value 3'b100.
- NOP request on req0 -> alu_op never equals ALU_NOP, rsp_valid0 pulses with rsp_data = 0 and rsp_flags = flags.
- flush in the cycle after a transfer -> no rsp_valid for that op, flags unchanged, no grant that cycle while req is held.
- rst pulsed between transfer and capture -> all outputs 0, no response. The next tie grants requester 0.
